fifo_rd_ptr_ctrl: RTL and testbench



---
 rtl/fifo_pkg.sv | 28 ++
 rtl/fifo_gray2bin.sv | 19 +
 rtl/fifo_rd_ptr_ctrl.sv | 91 +++++++++
 tb/tb_fifo_rd_ptr_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the async FIFO pointer controllers
// (read side and write side).
//   DEF_ADD_WIDTH : default RAM address width; depth = 2**DEF_ADD_WIDTH
//   ptr_t         : pointer type at the default width (address + wrap bit)
//   bin2gray      : binary -> Gray conversion
//   gray2bin      : Gray -> binary conversion (XOR prefix from the MSB down)
// Both conversions take and return 32-bit values. They work for any pointer
// width up to 32 bits: zero-extend the input and truncate the result.
package fifo_pkg;

   localparam int DEF_ADD_WIDTH = 3;

   typedef logic [DEF_ADD_WIDTH:0] ptr_t;

   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

   // Leading zeros from the zero-extension do not change the prefix XOR,
   // so the result is correct for any width up to 32 bits.
   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) r[i] = ^(g >> i);
      return r;
   endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// fifo_gray2bin: combinational Gray -> binary converter. It is used on the
// synchronized write pointer here and can be reused on the write side.
//   W      : pointer width in bits (at most 32)
//   gray_i : Gray-coded input
//   bin_o  : binary output
module fifo_gray2bin
   import fifo_pkg::*;
#(
   parameter int W = DEF_ADD_WIDTH + 1
) (
   input  logic [W-1:0] gray_i,
   output logic [W-1:0] bin_o
);

   always_comb begin
      bin_o = W'(gray2bin(32'(gray_i)));
   end

endmodule

// File: rtl/fifo_rd_ptr_ctrl.sv
// fifo_rd_ptr_ctrl: read-side pointer and flag controller for the async FIFO,
// clocked by rd_clk.
//   rd_clk, rd_rst     : clock and asynchronous active-low reset
//   rd_en              : read request from the consumer
//   wr_ptr_gray_sync   : Gray write pointer, already synchronized into rd_clk
//   rd_addr            : RAM read address (low bits of the binary read pointer)
//   rd_ptr_gray        : registered Gray read pointer, sent to the write domain
//   rd_empty           : registered empty flag
//   rd_almost_empty    : registered, level <= AEMPTY_THRESH
//   rd_level           : registered occupancy, 0 .. 2**ADD_WIDTH
//   rd_underflow       : read attempted while empty
// Build option RD_UNDERFLOW_STICKY_EN: when defined, rd_underflow latches on
// the first offending read and stays set until reset. Otherwise it pulses for
// one cycle per offending cycle.
module fifo_rd_ptr_ctrl
   import fifo_pkg::*;
#(
   parameter int ADD_WIDTH     = DEF_ADD_WIDTH,
   parameter int AEMPTY_THRESH = 1
) (
   input  logic               rd_clk,
   input  logic               rd_rst,
   input  logic               rd_en,
   input  logic [ADD_WIDTH:0] wr_ptr_gray_sync,
   output logic [ADD_WIDTH-1:0] rd_addr,
   output logic [ADD_WIDTH:0] rd_ptr_gray,
   output logic               rd_empty,
   output logic               rd_almost_empty,
   output logic [ADD_WIDTH:0] rd_level,
   output logic               rd_underflow
);

   localparam int PW = ADD_WIDTH + 1;

   logic [ADD_WIDTH:0] rd_bin_q, rd_bin_d;
   logic [ADD_WIDTH:0] rd_gray_q, rd_gray_d;
   logic [ADD_WIDTH:0] level_q, level_d;
   logic [ADD_WIDTH:0] wbin;
   logic               empty_q, empty_d;
   logic               aempty_q, aempty_d;
   logic               uflow_q, uflow_d;
   logic               rd_fire;

   fifo_gray2bin #(.W(PW)) u_wr_g2b (
      .gray_i (wr_ptr_gray_sync),
      .bin_o  (wbin)
   );

   always_comb begin
      // A read while empty is dropped, so the pointers stay where they are.
      rd_fire   = rd_en & ~empty_q;
      rd_bin_d  = rd_bin_q + {{ADD_WIDTH{1'b0}}, rd_fire};
      rd_gray_d = PW'(bin2gray(32'(rd_bin_d)));
      // Use the post-read pointer. A read and a write pointer update in the
      // same cycle then land in one level value.
      level_d   = wbin - rd_bin_d;
      empty_d   = (rd_gray_d == wr_ptr_gray_sync);
      aempty_d  = (level_d <= PW'(AEMPTY_THRESH));
`ifdef RD_UNDERFLOW_STICKY_EN
      uflow_d   = uflow_q | (rd_en & empty_q);
`else
      uflow_d   = rd_en & empty_q;
`endif
   end

   always_ff @(posedge rd_clk or negedge rd_rst) begin
      if (!rd_rst) begin
         rd_bin_q  <= '0;
         rd_gray_q <= '0;
         level_q   <= '0;
         empty_q   <= 1'b1;
         aempty_q  <= 1'b1;
         uflow_q   <= 1'b0;
      end else begin
         rd_bin_q  <= rd_bin_d;
         rd_gray_q <= rd_gray_d;
         level_q   <= level_d;
         empty_q   <= empty_d;
         aempty_q  <= aempty_d;
         uflow_q   <= uflow_d;
      end
   end

   assign rd_addr         = rd_bin_q[ADD_WIDTH-1:0];
   assign rd_ptr_gray     = rd_gray_q;
   assign rd_empty        = empty_q;
   assign rd_almost_empty = aempty_q;
   assign rd_level        = level_q;
   assign rd_underflow    = uflow_q;

endmodule

// File: tb/tb_fifo_rd_ptr_ctrl.sv
module tb_fifo_rd_ptr_ctrl;

   localparam int AW  = 3;
   localparam int AET = 1;
`ifdef RD_UNDERFLOW_STICKY_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   logic          rd_clk, rd_rst, rd_en;
   logic [AW:0]   wr_ptr_gray_sync;
   logic [AW-1:0] rd_addr;
   logic [AW:0]   rd_ptr_gray, rd_level;
   logic          rd_empty, rd_almost_empty, rd_underflow;

   fifo_rd_ptr_ctrl #(.ADD_WIDTH(AW), .AEMPTY_THRESH(AET)) dut (
      .rd_clk           (rd_clk),
      .rd_rst           (rd_rst),
      .rd_en            (rd_en),
      .wr_ptr_gray_sync (wr_ptr_gray_sync),
      .rd_addr          (rd_addr),
      .rd_ptr_gray      (rd_ptr_gray),
      .rd_empty         (rd_empty),
      .rd_almost_empty  (rd_almost_empty),
      .rd_level         (rd_level),
      .rd_underflow     (rd_underflow)
   );

   initial rd_clk = 1'b0;
   always #5 rd_clk = ~rd_clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: plain read count against the write count.
   int m_rcnt, m_level;
   bit m_empty, m_ae, m_uf;

   function automatic int g4(input int b);
      int x;
      x = b & 15;
      return x ^ (x >> 1);
   endfunction

   task automatic model_reset();
      m_rcnt = 0; m_level = 0; m_empty = 1'b1; m_ae = 1'b1; m_uf = 1'b0;
   endtask

   task automatic model_edge(input bit en, input int wcnt);
      bit bad;
      bad  = en && m_empty;
      m_uf = STICKY ? (m_uf || bad) : bad;
      if (en && !m_empty) m_rcnt++;
      m_level = wcnt - m_rcnt;
      m_empty = (m_level == 0);
      m_ae    = (m_level <= AET);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".empty"}, 32'(rd_empty), 32'(m_empty));
      chk({tag, ".level"}, 32'(rd_level), 32'(m_level));
      chk({tag, ".aempty"}, 32'(rd_almost_empty), 32'(m_ae));
      chk({tag, ".addr"}, 32'(rd_addr), 32'(m_rcnt % 8));
      chk({tag, ".gray"}, 32'(rd_ptr_gray), 32'(g4(m_rcnt)));
      chk({tag, ".uflow"}, 32'(rd_underflow), 32'(m_uf));
   endtask

   task automatic step(input bit en, input int wcnt, input string tag);
      rd_en = en;
      wr_ptr_gray_sync = 4'(g4(wcnt));
      @(posedge rd_clk);
      model_edge(en, wcnt);
      #1;
      chk_all(tag);
   endtask

   typedef struct {
      bit en; int w;
      bit e; int lvl; bit ae; int addr; logic [3:0] gray; bit uf;
   } vec_t;
   vec_t tbl[9];

   initial begin
      int wc;
      bit en;

      // Rows 0-5: the read side is empty or holds 2 entries. Rows 6-8 read
      // the last entry while a write arrives, then the FIFO drains.
      tbl[0] = '{1'b1, 0, 1'b1, 0, 1'b1, 0, 4'b0000, 1'b1};
      tbl[1] = '{1'b0, 0, 1'b1, 0, 1'b1, 0, 4'b0000, STICKY};
      tbl[2] = '{1'b0, 2, 1'b0, 2, 1'b0, 0, 4'b0000, STICKY};
      tbl[3] = '{1'b1, 2, 1'b0, 1, 1'b1, 1, 4'b0001, STICKY};
      tbl[4] = '{1'b1, 2, 1'b1, 0, 1'b1, 2, 4'b0011, STICKY};
      tbl[5] = '{1'b1, 2, 1'b1, 0, 1'b1, 2, 4'b0011, 1'b1};
      tbl[6] = '{1'b0, 3, 1'b0, 1, 1'b1, 2, 4'b0011, STICKY};
      tbl[7] = '{1'b1, 4, 1'b0, 1, 1'b1, 3, 4'b0010, STICKY};
      tbl[8] = '{1'b1, 4, 1'b1, 0, 1'b1, 4, 4'b0110, STICKY};

      rd_rst = 1'b0; rd_en = 1'b0; wr_ptr_gray_sync = '0;
      model_reset();
      repeat (2) @(negedge rd_clk);
      chk_all("reset");
      rd_rst = 1'b1;

      foreach (tbl[i]) begin
         rd_en = tbl[i].en;
         wr_ptr_gray_sync = 4'(g4(tbl[i].w));
         @(posedge rd_clk);
         model_edge(tbl[i].en, tbl[i].w);
         #1;
         chk($sformatf("tbl%0d.empty", i), 32'(rd_empty), 32'(tbl[i].e));
         chk($sformatf("tbl%0d.level", i), 32'(rd_level), 32'(tbl[i].lvl));
         chk($sformatf("tbl%0d.aempty", i), 32'(rd_almost_empty), 32'(tbl[i].ae));
         chk($sformatf("tbl%0d.addr", i), 32'(rd_addr), 32'(tbl[i].addr));
         chk($sformatf("tbl%0d.gray", i), 32'(rd_ptr_gray), 32'(tbl[i].gray));
         chk($sformatf("tbl%0d.uflow", i), 32'(rd_underflow), 32'(tbl[i].uf));
      end

      // Wrap: the write pointer moves to 9 and the reads cross bin 7 -> 8.
      step(1'b0, 9, "wrap_w");
      for (int k = 0; k < 5; k++) begin
         step(1'b1, 9, "wrap");
         if (m_rcnt == 7) begin
            chk("wrap7.gray", 32'(rd_ptr_gray), 32'h4);
            chk("wrap7.addr", 32'(rd_addr), 32'd7);
         end
         if (m_rcnt == 8) begin
            chk("wrap8.gray", 32'(rd_ptr_gray), 32'hC);
            chk("wrap8.addr", 32'(rd_addr), 32'd0);
         end
      end
      chk("wrap_end.empty", 32'(rd_empty), 32'd1);
      chk("wrap_end.gray", 32'(rd_ptr_gray), 32'hD);

      // Underflow: two reads while empty; the pointers must not move.
      step(1'b1, 9, "uf1");
      step(1'b1, 9, "uf2");
      chk("uf2.frozen_gray", 32'(rd_ptr_gray), 32'hD);
      step(1'b0, 9, "uf_after");
      chk("uf_after.uflow", 32'(rd_underflow), 32'(STICKY));

      // Assert reset with level 3. The outputs must clear without a clock edge.
      step(1'b0, 12, "pre_rst");
      chk("pre_rst.level", 32'(rd_level), 32'd3);
      #2;
      rd_rst = 1'b0;
      wr_ptr_gray_sync = '0;
      #1;
      model_reset();
      chk_all("rst_async");
      @(negedge rd_clk);
      rd_rst = 1'b1;
      step(1'b0, 0, "post_rst");
      step(1'b1, 0, "post_rst_rd");

      // Random traffic; writes are held back so the FIFO never exceeds full.
      wc = 0;
      for (int c = 0; c < 400; c++) begin
         en = 1'($urandom % 2);
         if ((wc - m_rcnt) < 8 && ($urandom % 2) == 1) wc++;
         step(en, wc, "rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
